// File: rtl/cmp_iter_if.sv
// Request/response bundle for the iterative comparator.
interface cmp_iter_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_signed;
  logic             o_valid;
  logic             i_ready;
  logic             o_lt;
  logic             o_eq;
  logic [WIDTH-1:0] o_result;
  logic [WIDTH-1:0] o_min;
  logic [WIDTH-1:0] o_max;

  modport master (
    output i_valid, i_a, i_b, i_signed, i_ready,
    input  o_ready, o_valid, o_lt, o_eq, o_result, o_min, o_max
  );

  modport slave (
    input  i_valid, i_a, i_b, i_signed, i_ready,
    output o_ready, o_valid, o_lt, o_eq, o_result, o_min, o_max
  );
endinterface

// File: rtl/cmp_iter.sv
// Iterative magnitude comparator: scans CHUNK bits per cycle, MS chunk first.
// Optional min/max outputs enabled by defining CMP_ITER_MINMAX_EN.
module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  cmp_iter_if.slave  bus
);
  localparam int NCHK = WIDTH / CHUNK;
  localparam int JW   = (NCHK > 1) ? $clog2(NCHK) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             lt_q, lt_d, eq_q, eq_d;

  logic [WIDTH-1:0]             a_bias, b_bias;
  logic [NCHK-1:0][CHUNK-1:0]   a_ch, b_ch;
  logic [CHUNK-1:0]             ca, cb;
  logic                         last;
  logic                         done_ent;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_bias = a_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
  assign b_bias = b_q ^ {sgn_q, {(WIDTH-1){1'b0}}};

  // Chunk 0 is the most significant slice.
  for (genvar g = 0; g < NCHK; g++) begin : g_chunk
    assign a_ch[g] = a_bias[WIDTH-1-g*CHUNK -: CHUNK];
    assign b_ch[g] = b_bias[WIDTH-1-g*CHUNK -: CHUNK];
  end

  assign ca       = a_ch[j_q];
  assign cb       = b_ch[j_q];
  assign last     = (j_q == JW'(NCHK-1));
  assign done_ent = (state_q == CMP) && (state_d == DONE);

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          sgn_d   = bus.i_signed;
          j_d     = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (ca != cb) begin
          lt_d    = (ca < cb);
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (last) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

`ifdef CMP_ITER_MINMAX_EN
  logic [WIDTH-1:0] min_q, max_q;

  // a_q/b_q hold the unbiased operands, so selection uses original values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else if (done_ent) begin
      min_q <= lt_d ? a_q : b_q;
      max_q <= lt_d ? b_q : a_q;
    end
  end

  assign bus.o_min = min_q;
  assign bus.o_max = max_q;
`else
  assign bus.o_min = '0;
  assign bus.o_max = '0;
`endif

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_lt     = lt_q;
  assign bus.o_eq     = eq_q;
  assign bus.o_result = {{(WIDTH-1){1'b0}}, lt_q};
endmodule

// File: tb/tb_cmp_iter.sv
// Directed and random checks for cmp_iter (WIDTH=32, CHUNK=8).
module tb_cmp_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_iter_if #(.WIDTH(32)) bus ();
  cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  logic        r_ok, r_lt, r_eq;
  logic [31:0] r_res, r_min, r_max;
  int          r_lat;

  function automatic logic [31:0] exp_min(input logic lt, input logic [31:0] a, b);
`ifdef CMP_ITER_MINMAX_EN
    return lt ? a : b;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_max(input logic lt, input logic [31:0] a, b);
`ifdef CMP_ITER_MINMAX_EN
    return lt ? b : a;
`else
    return 32'h0;
`endif
  endfunction

  // Issue one request, scramble the operand pins after accept, wait for o_valid.
  task automatic run_req(input logic [31:0] a, b, input logic s, input bit consume);
    int k;
    @(negedge clk);
    bus.i_a = a; bus.i_b = b; bus.i_signed = s; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_a = ~a; bus.i_b = ~b; bus.i_signed = ~s;
    r_lat = 0; k = 0;
    while (!bus.o_valid && k < 20) begin
      @(posedge clk); #1;
      r_lat++; k++;
    end
    r_ok  = bus.o_valid;
    r_lt  = bus.o_lt;
    r_eq  = bus.o_eq;
    r_res = bus.o_result;
    r_min = bus.o_min;
    r_max = bus.o_max;
    if (consume) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_a = '0; bus.i_b = '0; bus.i_signed = 1'b0;
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01)
      $display("FAIL reset_hs: valid/ready got %b want 01", {bus.o_valid, bus.o_ready});
    else n_pass++;
    n_chk++;
    if ({bus.o_lt, bus.o_eq, bus.o_result} !== 34'h0)
      $display("FAIL reset_flags: lt=%b eq=%b res=%h want all 0", bus.o_lt, bus.o_eq, bus.o_result);
    else n_pass++;
    n_chk++;
    if ({bus.o_min, bus.o_max} !== 64'h0)
      $display("FAIL reset_minmax: min=%h max=%h want 0", bus.o_min, bus.o_max);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed(input string nm, input logic [31:0] a, b, input logic s,
                               input logic lt, input logic eq, input int lat);
    run_req(a, b, s, 1'b1);
    n_chk++;
    if (!r_ok || r_lat != lat)
      $display("FAIL %s_lat: valid=%b latency got %0d want %0d", nm, r_ok, r_lat, lat);
    else n_pass++;
    n_chk++;
    if ({r_lt, r_eq, r_res} !== {lt, eq, 31'h0, lt})
      $display("FAIL %s_res: lt=%b eq=%b res=%h want lt=%b eq=%b", nm, r_lt, r_eq, r_res, lt, eq);
    else n_pass++;
    n_chk++;
    if (r_min !== exp_min(lt, a, b) || r_max !== exp_max(lt, a, b))
      $display("FAIL %s_minmax: min=%h max=%h want min=%h max=%h", nm, r_min, r_max,
               exp_min(lt, a, b), exp_max(lt, a, b));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_req(32'h0000_00FF, 32'h0000_0100, 1'b0, 1'b1);
    n_chk++;
    if (!bus.o_ready || bus.o_valid)
      $display("FAIL b2b_idle: ready=%b valid=%b want 1/0", bus.o_ready, bus.o_valid);
    else n_pass++;
    run_req(32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b1);
    n_chk++;
    if (!r_ok || r_lat != 3 || r_lt !== 1'b0 || r_eq !== 1'b0)
      $display("FAIL b2b_second: lat=%0d lt=%b eq=%b want 3/0/0", r_lat, r_lt, r_eq);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bus.i_ready = 1'b0;
    run_req(32'h0000_0010, 32'h0000_1000, 1'b0, 1'b0);
    n_chk++;
    if (!r_ok || r_lat != 3 || r_lt !== 1'b1)
      $display("FAIL bp_first: valid=%b lat=%0d lt=%b want 1/3/1", r_ok, r_lat, r_lt);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_a = 32'h0; bus.i_b = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      if (!bus.o_valid || bus.o_ready || bus.o_lt !== 1'b1 || bus.o_eq !== 1'b0 || bus.o_result !== 32'h1)
        bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL bp_hold: %0d cycles lost hold, want 0", bad);
    else n_pass++;
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.o_valid || !bus.o_ready || bus.o_lt !== 1'b1)
      $display("FAIL bp_release: valid=%b ready=%b lt=%b want 0/1/1", bus.o_valid, bus.o_ready, bus.o_lt);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (bus.o_valid || !bus.o_ready)
      $display("FAIL bp_no_accept: valid=%b ready=%b want 0/1", bus.o_valid, bus.o_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    bus.i_a = 32'h8000_0000; bus.i_b = 32'h7FFF_FFFF; bus.i_signed = 1'b1; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    n_chk++;
    if (bus.o_ready) $display("FAIL rmid_cmp: ready got 1 want 0");
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.o_valid || !bus.o_ready || bus.o_lt || bus.o_eq || bus.o_result !== 32'h0 ||
        bus.o_min !== 32'h0 || bus.o_max !== 32'h0)
      $display("FAIL rmid_zero: valid=%b ready=%b lt=%b eq=%b res=%h min=%h max=%h",
               bus.o_valid, bus.o_ready, bus.o_lt, bus.o_eq, bus.o_result, bus.o_min, bus.o_max);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.o_valid || !bus.o_ready) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL rmid_quiet: %0d cycles with valid after reset, want 0", bad);
    else n_pass++;
    test_directed("rmid_redo", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1);
  endtask

  task automatic test_random();
    int bad = 0;
    logic [31:0] a, b;
    logic s, lt, eq;
    int jf, sel;
    for (int n = 0; n < 10000; n++) begin
      a = $urandom; s = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      if (sel == 5) b = a;
      else if (sel == 4) b = $urandom;
      else b = a ^ (32'($urandom_range(0, 255)) << (8 * (3 - sel)));
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      eq = (a == b);
      jf = 3;
      for (int j = 3; j >= 0; j--)
        if (a[31-8*j -: 8] != b[31-8*j -: 8]) jf = j;
      run_req(a, b, s, 1'b1);
      if (!r_ok || r_lat != jf + 1 || r_lt !== lt || r_eq !== eq || r_res !== {31'h0, lt} ||
          r_min !== exp_min(lt, a, b) || r_max !== exp_max(lt, a, b)) begin
        if (bad < 5)
          $display("FAIL rand: a=%h b=%h s=%b lt=%b eq=%b lat=%0d want lt=%b eq=%b lat=%0d",
                   a, b, s, r_lt, r_eq, r_lat, lt, eq, jf + 1);
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) $display("FAIL rand_total: %0d mismatching pairs, want 0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed("sgn_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1);
    test_directed("uns_big", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1);
    test_directed("equal",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 4);
    test_directed("equal_s", 32'h8765_4321, 32'h8765_4321, 1'b1, 1'b0, 1'b1, 4);
    test_directed("lsb_lt",  32'h1234_5600, 32'h1234_5601, 1'b0, 1'b1, 1'b0, 4);
    test_directed("lsb_gt",  32'h1234_5601, 32'h1234_5600, 1'b0, 1'b0, 1'b0, 4);
    test_directed("sgn_mid", 32'hFFFF_8000, 32'hFFFF_7FFF, 1'b1, 1'b0, 1'b0, 3);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cmp_iter.md
CMP_ITER -- requirements
Module: cmp_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal: 8..64).
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle (legal: divides WIDTH; WIDTH/CHUNK = NCHK).
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  block can accept request.
REQ-007 SHALL have ports i_a, i_b  input  WIDTH  operands.
REQ-008 SHALL have port i_signed  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports o_lt, o_eq  output  1  a<b, a==b.
REQ-012 SHALL have port o_result  output  WIDTH  zero-extended o_lt (SLT/SLTU write-back form).
REQ-013 SHALL have ports o_min, o_max  output  WIDTH  selected operands (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, CMP, DONE.
REQ-015 IDLE: o_ready=1; on i_valid&&o_ready SHALL latch i_a, i_b, i_signed, set chunk index j=0, go CMP.
REQ-016 Signed mode SHALL invert bit WIDTH-1 of both latched operands before scanning, so the scan is purely unsigned.
REQ-017 CMP: each cycle SHALL compare chunk j (j=0 = most significant CHUNK bits); on mismatch SHALL set lt from the chunk compare, eq=0, go DONE.
REQ-018 CMP: on match with j==NCHK-1 SHALL set lt=0, eq=1, go DONE; on match otherwise j increments.
REQ-019 Latency SHALL be j_first+1 cycles from accept edge to o_valid, j_first = index of first differing chunk (NCHK-1 if equal); max NCHK, min 1.
REQ-020 DONE: o_valid=1, outputs stable; SHALL hold until i_ready=1, then go IDLE next edge.
REQ-021 o_ready SHALL be 1 only in IDLE; no acceptance in DONE or CMP (i_valid ignored there).
REQ-022 o_lt, o_eq, o_result, o_min, o_max SHALL be registered and change only on entering DONE or on reset.
REQ-023 o_lt and o_eq SHALL never both be 1.
REQ-024 Operand inputs changing after accept SHALL not affect the in-flight result.

Reset
REQ-025 i_rst_n=0 SHALL immediately force IDLE, o_valid=0, o_ready=1 after release, o_lt=0, o_eq=0, o_result=0, o_min=0, o_max=0, j=0.
REQ-026 Reset asserted in CMP or DONE SHALL discard the in-flight request; no o_valid pulse after release.

Configuration
REQ-027 Macro CMP_ITER_MINMAX_EN defined: o_min = lt ? a : b, o_max = lt ? b : a, using original (unbiased) latched operands.
REQ-028 Macro CMP_ITER_MINMAX_EN undefined: o_min, o_max SHALL be constant 0 and operand-copy registers SHALL be omitted; all other behaviour unchanged.

Verification (WIDTH=32, CHUNK=8)
REQ-029 a=0xFFFFFFFF, b=0x00000001, signed -> o_lt=1, o_eq=0, o_result=1, latency 1, o_min=0xFFFFFFFF (MINMAX_EN).
REQ-030 Same operands, unsigned -> o_lt=0, o_eq=0, o_result=0, latency 1, o_max=0xFFFFFFFF (MINMAX_EN).
REQ-031 a=b=0x12345678 -> o_eq=1, o_lt=0, latency 4; a=0x12345600, b=0x12345601 unsigned -> o_lt=1, latency 4.
REQ-032 Result with i_ready=0 for 3 cycles -> o_valid and outputs held, o_ready=0, new i_valid ignored; i_ready=1 -> IDLE next edge.
REQ-033 i_rst_n pulsed low during CMP (a=0x80000000, b=0x7FFFFFFF signed) -> all outputs 0, IDLE, no o_valid after release.
REQ-034 Random signed/unsigned pairs (≥10k) vs golden model; latency matches REQ-019.
